// File: rtl/pipeline_ctrl_pkg.sv
// Shared state encodings, counter width and stage-control payloads for the hazard controller.
package pipeline_ctrl_pkg;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned STATE_W = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [STATE_W-1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HOLD  = 2'd3
    } ctrl_state_e;

    // Stage enables and NOP-insertion controls driven toward the pipeline.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic bubble_id_ex;
        logic flush_if_id;
        logic flush_ex_mem;
        logic pc_sel;
    } ctrl_out_t;

    localparam ctrl_out_t OUT_DEFAULT = '{pc_write: 1'b1, if_id_write: 1'b1, bubble_id_ex: 1'b0,
                                          flush_if_id: 1'b0, flush_ex_mem: 1'b0, pc_sel: 1'b0};
    localparam ctrl_out_t OUT_REDIRECT = '{pc_write: 1'b1, if_id_write: 1'b1, bubble_id_ex: 1'b1,
                                           flush_if_id: 1'b1, flush_ex_mem: 1'b1, pc_sel: 1'b1};
    localparam ctrl_out_t OUT_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, bubble_id_ex: 1'b1,
                                         flush_if_id: 1'b0, flush_ex_mem: 1'b0, pc_sel: 1'b0};

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned PC_SIZE = 10,
    parameter int unsigned REG_AW  = 5
);
    import pipeline_ctrl_pkg::*;

    logic [REG_AW-1:0]  rs1_id;
    logic [REG_AW-1:0]  rs2_id;
    logic               use_rs2_id;
    logic [REG_AW-1:0]  rd_ex;
    logic               mem_read_ex;
    logic               branch_mem;
    logic               zero_mem;
    logic [PC_SIZE-1:0] PC_jump_mem;
    logic               hold_req;
    logic               clr_cnt;

    logic               pc_write;
    logic               if_id_write;
    logic               bubble_id_ex;
    logic               flush_if_id;
    logic               flush_ex_mem;
    logic               pc_sel;
    logic [PC_SIZE-1:0] pc_target;
    logic               hold_ack;
    logic [STATE_W-1:0] state_o;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport master (
        output rs1_id, rs2_id, use_rs2_id, rd_ex, mem_read_ex,
               branch_mem, zero_mem, PC_jump_mem, hold_req, clr_cnt,
        input  pc_write, if_id_write, bubble_id_ex, flush_if_id, flush_ex_mem,
               pc_sel, pc_target, hold_ack, state_o, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_id, rs2_id, use_rs2_id, rd_ex, mem_read_ex,
               branch_mem, zero_mem, PC_jump_mem, hold_req, clr_cnt,
        output pc_write, if_id_write, bubble_id_ex, flush_if_id, flush_ex_mem,
               pc_sel, pc_target, hold_ack, state_o, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use and taken-branch detection.
module hazard_detect #(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs1_id,
    input  logic [REG_AW-1:0] i_rs2_id,
    input  logic              i_use_rs2_id,
    input  logic [REG_AW-1:0] i_rd_ex,
    input  logic              i_mem_read_ex,
    input  logic              i_branch_mem,
    input  logic              i_zero_mem,
    output logic              o_taken_c,
    output logic              o_load_use_c
);

    logic w_rd_nonzero;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is never a real producer, so a load into it cannot create a hazard.
    assign w_rd_nonzero = (i_rd_ex != '0);
    assign w_rs1_hit    = (i_rd_ex == i_rs1_id);
    assign w_rs2_hit    = i_use_rs2_id && (i_rd_ex == i_rs2_id);

    assign o_taken_c    = i_branch_mem && i_zero_mem;
    assign o_load_use_c = i_mem_read_ex && w_rd_nonzero && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: stall/flush/hold FSM, debug hold handshake and event counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned PC_SIZE = 10,
    parameter int unsigned REG_AW  = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus
);

    ctrl_state_e        r_state;
    ctrl_state_e        w_next_state;
    ctrl_out_t          w_out;
    logic               r_hold_ack;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic               w_taken;
    logic               w_load_use;
    logic               w_stall_inc;
    logic               w_flush_inc;
    logic [PC_SIZE-1:0] w_pc_target;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
        .i_rs1_id      (bus.rs1_id),
        .i_rs2_id      (bus.rs2_id),
        .i_use_rs2_id  (bus.use_rs2_id),
        .i_rd_ex       (bus.rd_ex),
        .i_mem_read_ex (bus.mem_read_ex),
        .i_branch_mem  (bus.branch_mem),
        .i_zero_mem    (bus.zero_mem),
        .o_taken_c     (w_taken),
        .o_load_use_c  (w_load_use)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: a taken branch wins everywhere except FLUSH, which always drains back to RUN.
    always_comb begin
        w_next_state = ST_RUN;
        case (r_state)
            ST_RUN: begin
                if (w_taken)          w_next_state = ST_FLUSH;
                else if (w_load_use)  w_next_state = ST_STALL;
                else if (bus.hold_req) w_next_state = ST_HOLD;
                else                  w_next_state = ST_RUN;
            end
            ST_STALL: w_next_state = w_taken ? ST_FLUSH : ST_RUN;
            ST_FLUSH: w_next_state = ST_RUN;
            ST_HOLD: begin
                if (w_taken)           w_next_state = ST_FLUSH;
                else if (bus.hold_req) w_next_state = ST_HOLD;
                else                   w_next_state = ST_RUN;
            end
            default: w_next_state = ST_RUN;
        endcase
    end

    // Stage controls for the current cycle; forced to pass-through while reset is low.
    always_comb begin
        w_out = OUT_DEFAULT;
        if (reset) begin
            case (r_state)
                ST_RUN: begin
                    if (w_taken)         w_out = OUT_REDIRECT;
                    else if (w_load_use) w_out = OUT_FREEZE;
                end
                ST_STALL: begin
                    if (w_taken) w_out = OUT_REDIRECT;
                end
                ST_HOLD:  w_out = w_taken ? OUT_REDIRECT : OUT_FREEZE;
                default:  w_out = OUT_DEFAULT;
            endcase
        end
    end

    // Counter events: stall entries plus every cycle spent in HOLD; flush entries.
    assign w_stall_inc = (r_state == ST_HOLD) || (w_next_state == ST_STALL);
    assign w_flush_inc = (w_next_state == ST_FLUSH);

    // Hold acknowledge tracks residency in HOLD, so it rises on the first HOLD cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hold_ack <= 1'b0;
        end else begin
            r_hold_ack <= (w_next_state == ST_HOLD);
        end
    end

    // Saturating event counters with a clear that overrides any increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (bus.clr_cnt) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_stall_cnt <= sat_inc(r_stall_cnt, w_stall_inc);
            r_flush_cnt <= sat_inc(r_flush_cnt, w_flush_inc);
        end
    end

    assign w_pc_target = bus.PC_jump_mem;

    assign bus.pc_write     = w_out.pc_write;
    assign bus.if_id_write  = w_out.if_id_write;
    assign bus.bubble_id_ex = w_out.bubble_id_ex;
    assign bus.flush_if_id  = w_out.flush_if_id;
    assign bus.flush_ex_mem = w_out.flush_ex_mem;
    assign bus.pc_sel       = w_out.pc_sel;
    assign bus.pc_target    = w_pc_target;
    assign bus.hold_ack     = r_hold_ack;
    assign bus.state_o      = STATE_W'(r_state);
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized bench for pipeline_hazard_ctrl against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned PC_SIZE = 10;
    localparam int unsigned REG_AW  = 5;
    localparam int S_RUN   = 0;
    localparam int S_STALL = 1;
    localparam int S_FLUSH = 2;
    localparam int S_HOLD  = 3;
    localparam int CNT_TOP = 65535;

    logic clock = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    // Reference model registers and their values for the next edge.
    int m_state, m_stall, m_flush, m_ack;
    int n_state, n_stall, n_flush, n_ack;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl_if #(.PC_SIZE(PC_SIZE), .REG_AW(REG_AW)) bus ();

    pipeline_hazard_ctrl #(.PC_SIZE(PC_SIZE), .REG_AW(REG_AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        m_state = S_RUN; m_stall = 0; m_flush = 0; m_ack = 0;
        n_state = S_RUN; n_stall = 0; n_flush = 0; n_ack = 0;
    endtask

    task automatic clear_inputs();
        bus.rs1_id = '0; bus.rs2_id = '0; bus.use_rs2_id = 1'b0;
        bus.rd_ex = '0; bus.mem_read_ex = 1'b0;
        bus.branch_mem = 1'b0; bus.zero_mem = 1'b0; bus.PC_jump_mem = '0;
        bus.hold_req = 1'b0; bus.clr_cnt = 1'b0;
    endtask

    // At the falling edge: predict this cycle's outputs from the rules, compare, and prepare next state.
    task automatic eval_cycle();
        bit taken, lu, redirect, freeze;
        int nxt;
        @(negedge clock);
        taken = bus.branch_mem && bus.zero_mem;
        lu = bus.mem_read_ex && (bus.rd_ex != 0) &&
             ((bus.rd_ex == bus.rs1_id) || (bus.use_rs2_id && (bus.rd_ex == bus.rs2_id)));
        redirect = reset && taken && (m_state != S_FLUSH);
        freeze   = reset && !redirect && ((m_state == S_RUN && lu) || m_state == S_HOLD);
        if (redirect)                                               nxt = S_FLUSH;
        else if (m_state == S_RUN && lu)                            nxt = S_STALL;
        else if ((m_state == S_RUN || m_state == S_HOLD) && bus.hold_req) nxt = S_HOLD;
        else                                                        nxt = S_RUN;

        check("pc_write",     32'(bus.pc_write),     32'(!freeze));
        check("if_id_write",  32'(bus.if_id_write),  32'(!freeze));
        check("bubble_id_ex", 32'(bus.bubble_id_ex), 32'(freeze || redirect));
        check("flush_if_id",  32'(bus.flush_if_id),  32'(redirect));
        check("flush_ex_mem", 32'(bus.flush_ex_mem), 32'(redirect));
        check("pc_sel",       32'(bus.pc_sel),       32'(redirect));
        check("pc_target",    32'(bus.pc_target),    32'(bus.PC_jump_mem));
        check("state_o",      32'(bus.state_o),      32'(m_state));
        check("hold_ack",     32'(bus.hold_ack),     32'(m_ack));
        check("stall_cnt",    32'(bus.stall_cnt),    32'(m_stall));
        check("flush_cnt",    32'(bus.flush_cnt),    32'(m_flush));

        if (bus.clr_cnt) begin
            n_stall = 0;
            n_flush = 0;
        end else begin
            n_stall = m_stall + ((m_state == S_HOLD || nxt == S_STALL) ? 1 : 0);
            n_flush = m_flush + ((nxt == S_FLUSH) ? 1 : 0);
            if (n_stall > CNT_TOP) n_stall = CNT_TOP;
            if (n_flush > CNT_TOP) n_flush = CNT_TOP;
        end
        n_state = nxt;
        n_ack   = (nxt == S_HOLD) ? 1 : 0;
    endtask

    // At the rising edge: advance the model, then move just past the edge to drive new inputs.
    task automatic commit();
        @(posedge clock);
        if (!reset) begin
            model_zero();
        end else begin
            m_state = n_state; m_stall = n_stall; m_flush = n_flush; m_ack = n_ack;
        end
        #1;
    endtask

    task automatic cycle();
        eval_cycle();
        commit();
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        model_zero();

        // Reset state
        eval_cycle();
        check("rst_state", 32'(bus.state_o), 32'd0);
        check("rst_pc_write", 32'(bus.pc_write), 32'd1);
        check("rst_cnt", 32'(bus.stall_cnt), 32'd0);
        commit();
        reset = 1'b1;
        cycle();

        // Load-use on rs1: one-cycle freeze, then STALL releases, back to RUN
        bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd5; bus.rs1_id = 5'd5;
        eval_cycle();
        check("lu_pc_write", 32'(bus.pc_write), 32'd0);
        check("lu_bubble", 32'(bus.bubble_id_ex), 32'd1);
        commit();
        eval_cycle();
        check("lu_in_stall", 32'(bus.state_o), 32'd1);
        check("lu_released", 32'(bus.pc_write), 32'd1);
        commit();
        clear_inputs();
        eval_cycle();
        check("lu_back_run", 32'(bus.state_o), 32'd0);
        check("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
        commit();

        // No stall: load into x0, and rs2 match while rs2 is unused
        bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd0; bus.rs1_id = 5'd0;
        eval_cycle();
        check("x0_no_stall", 32'(bus.pc_write), 32'd1);
        commit();
        bus.rd_ex = 5'd7; bus.rs2_id = 5'd7; bus.rs1_id = 5'd3; bus.use_rs2_id = 1'b0;
        eval_cycle();
        check("rs2_unused_no_stall", 32'(bus.pc_write), 32'd1);
        check("rs2_unused_state", 32'(bus.state_o), 32'd0);
        commit();
        clear_inputs();
        bus.clr_cnt = 1'b1;
        cycle();
        bus.clr_cnt = 1'b0;

        // Taken branch with a simultaneous load-use: branch wins
        bus.branch_mem = 1'b1; bus.zero_mem = 1'b1; bus.PC_jump_mem = 10'h123;
        bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd5; bus.rs1_id = 5'd5;
        eval_cycle();
        check("br_pc_sel", 32'(bus.pc_sel), 32'd1);
        check("br_target", 32'(bus.pc_target), 32'h123);
        check("br_flushes", {29'd0, bus.flush_if_id, bus.bubble_id_ex, bus.flush_ex_mem}, 32'd7);
        check("br_no_stall", 32'(bus.pc_write), 32'd1);
        commit();
        eval_cycle();
        check("br_in_flush", 32'(bus.state_o), 32'd2);
        check("br_flush_ignores", 32'(bus.pc_sel), 32'd0);
        commit();
        clear_inputs();
        eval_cycle();
        check("br_back_run", 32'(bus.state_o), 32'd0);
        check("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);
        check("br_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        commit();

        // Debug hold for four request cycles
        bus.clr_cnt = 1'b1;
        cycle();
        bus.clr_cnt = 1'b0;
        bus.hold_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eval_cycle();
            if (i >= 1) begin
                check("hold_ack_hi", 32'(bus.hold_ack), 32'd1);
                check("hold_pc_write", 32'(bus.pc_write), 32'd0);
            end
            commit();
        end
        bus.hold_req = 1'b0;
        eval_cycle();
        check("hold_exit_cycle", 32'(bus.state_o), 32'd3);
        commit();
        eval_cycle();
        check("hold_run", 32'(bus.state_o), 32'd0);
        check("hold_ack_lo", 32'(bus.hold_ack), 32'd0);
        check("hold_stall_cnt", 32'(bus.stall_cnt), 32'd4);
        commit();

        // Saturation: 65534 hold cycles, then three load-use stalls
        bus.clr_cnt = 1'b1;
        cycle();
        bus.clr_cnt = 1'b0;
        bus.hold_req = 1'b1;
        for (int i = 0; i < 65534; i++) cycle();
        bus.hold_req = 1'b0;
        cycle();
        eval_cycle();
        check("sat_preload", 32'(bus.stall_cnt), 32'd65534);
        commit();
        bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd9; bus.rs2_id = 5'd9; bus.use_rs2_id = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        clear_inputs();
        eval_cycle();
        check("sat_stall_cnt", 32'(bus.stall_cnt), 32'hFFFF);
        commit();
        bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd9; bus.rs1_id = 5'd9; bus.clr_cnt = 1'b1;
        cycle();
        clear_inputs();
        eval_cycle();
        check("clr_beats_inc", 32'(bus.stall_cnt), 32'd0);
        commit();

        // Randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(99) == 0) begin
                reset = 1'b0;
                model_zero();
            end else begin
                reset = 1'b1;
            end
            bus.rs1_id      = REG_AW'($urandom_range(3));
            bus.rs2_id      = REG_AW'($urandom_range(3));
            bus.rd_ex       = REG_AW'($urandom_range(3));
            bus.use_rs2_id  = 1'($urandom_range(1));
            bus.mem_read_ex = 1'($urandom_range(1));
            bus.branch_mem  = ($urandom_range(3) == 0);
            bus.zero_mem    = ($urandom_range(1) == 0);
            bus.PC_jump_mem = PC_SIZE'($urandom);
            bus.hold_req    = ($urandom_range(9) < 3);
            bus.clr_cnt     = ($urandom_range(29) == 0);
            cycle();
        end
        reset = 1'b1;
        clear_inputs();
        cycle();
        cycle();

        // Asynchronous reset in the middle of HOLD
        bus.branch_mem = 1'b1; bus.zero_mem = 1'b1;
        cycle();
        clear_inputs();
        cycle();
        bus.hold_req = 1'b1;
        cycle();
        cycle();
        #2;
        reset = 1'b0;
        bus.branch_mem = 1'b1; bus.zero_mem = 1'b1;
        #1;
        check("arst_state", 32'(bus.state_o), 32'd0);
        check("arst_ack", 32'(bus.hold_ack), 32'd0);
        check("arst_cnt", {bus.stall_cnt, bus.flush_cnt}, 32'd0);
        check("arst_pc_sel", 32'(bus.pc_sel), 32'd0);
        model_zero();
        cycle();
        reset = 1'b1;
        clear_inputs();
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter PC_SIZE, default 10, program-counter width.
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL have ports `clock  in  1  sole clock`; `reset  in  1  asynchronous, active-low reset`.
REQ-004 SHALL have inputs `rs1_id, rs2_id  in  REG_AW` (ID-stage source registers) and `use_rs2_id  in  1` (ID instruction reads rs2).
REQ-005 SHALL have inputs `rd_ex  in  REG_AW` and `mem_read_ex  in  1` (EX-stage destination and load flag).
REQ-006 SHALL have inputs `branch_mem, zero_mem  in  1` and `PC_jump_mem  in  PC_SIZE` (registered EX outputs, now in MEM).
REQ-007 SHALL have inputs `hold_req  in  1` (debug halt request) and `clr_cnt  in  1` (synchronous counter clear).
REQ-008 SHALL have outputs `pc_write, if_id_write  out  1` (stage enables); `bubble_id_ex, flush_if_id, flush_ex_mem  out  1` (insert NOP controls).
REQ-009 SHALL have outputs `pc_sel  out  1` (select redirect) and `pc_target  out  PC_SIZE` (redirect address).
REQ-010 SHALL have outputs `hold_ack  out  1`, `state_o  out  2`, `stall_cnt, flush_cnt  out  16`.

Function
REQ-011 SHALL define taken = branch_mem & zero_mem.
REQ-012 SHALL define load_use = mem_read_ex & (rd_ex != 0) & ((rd_ex == rs1_id) | (use_rs2_id & rd_ex == rs2_id)).
REQ-013 SHALL implement the FSM states RUN=0, STALL=1, FLUSH=2, HOLD=3, exposed on state_o.
REQ-014 Default outputs (no action) SHALL be pc_write=1, if_id_write=1, all bubble/flush signals=0, pc_sel=0, pc_target=PC_jump_mem.
REQ-015 In RUN or STALL with taken, the block SHALL, in the same cycle, assert pc_sel and flush_if_id, bubble_id_ex and flush_ex_mem, and go to FLUSH. taken has highest priority.
REQ-016 In RUN with load_use and not taken, the block SHALL, in the same cycle, drive pc_write=0, if_id_write=0 and bubble_id_ex=1, and go to STALL. The penalty SHALL be exactly one cycle.
REQ-017 In RUN with hold_req and neither taken nor load_use, the block SHALL go to HOLD.
REQ-018 In RUN with no event, the block SHALL stay in RUN.
REQ-019 In STALL without taken, the block SHALL drive default outputs, ignore load_use (that hazard is already resolved) and return to RUN.
REQ-020 In FLUSH, the block SHALL drive default outputs, ignore taken, load_use and hold_req (the stages hold bubbles) and return to RUN.
REQ-021 In HOLD, the block SHALL drive pc_write=0, if_id_write=0 and bubble_id_ex=1, and assert hold_ack (registered, high from the first HOLD cycle).
REQ-022 The block SHALL leave HOLD for RUN on the first cycle hold_req is low. hold_ack SHALL drop in that same cycle. taken arriving in HOLD SHALL still be serviced per REQ-015, exiting to FLUSH.
REQ-023 stall_cnt SHALL increment on each STALL entry and each HOLD cycle. flush_cnt SHALL increment on each FLUSH entry.
REQ-024 Both counters SHALL saturate at 16'hFFFF (no wrap).
REQ-025 clr_cnt SHALL zero both counters next edge and take priority over a simultaneous increment.

Reset
REQ-026 While reset=0, the block SHALL asynchronously force state=RUN, hold_ack=0 and stall_cnt=flush_cnt=0.
REQ-027 Combinational outputs SHALL take RUN default values during reset.
REQ-028 Reset asserted mid-STALL, FLUSH or HOLD SHALL abandon that state with no residual effect.
REQ-029 Reset deassertion SHALL be synchronized by the integrator. The first post-reset edge SHALL evaluate RUN rules.

Structure
REQ-030 State encodings and counter width SHALL live in a shared package pipeline_ctrl_pkg.
REQ-031 The hazard/branch detection equations SHALL live in one combinational sub-module, hazard_detect.
REQ-032 The FSM, hold handshake and counters SHALL live in the top module.

Verification
REQ-033 Load-use test: mem_read_ex=1, rd_ex=5, rs1_id=5 in RUN -> pc_write=0, bubble_id_ex=1 for exactly 1 cycle, then STALL->RUN, stall_cnt=1.
REQ-034 No-stall test: rd_ex=0 with rs1_id=0 and mem_read_ex=1 -> no stall. rd_ex=7, rs2_id=7, use_rs2_id=0 -> no stall.
REQ-035 Branch test: branch_mem=1, zero_mem=1, PC_jump_mem=10'h123 with load_use also true -> pc_sel=1, pc_target=10'h123, all three flushes, no stall, FLUSH then RUN, flush_cnt=1.
REQ-036 Hold test: hold_req high for 4 cycles -> hold_ack high from cycle 2, pc_write=0 throughout, stall_cnt=4. hold_req low -> RUN and hold_ack=0 that cycle.
REQ-037 Saturation test: preload 65534 stalls, then 3 more -> stall_cnt=16'hFFFF. clr_cnt together with a stall -> 0.
REQ-038 Reset test: reset=0 asserted mid-HOLD -> immediately state_o=0, hold_ack=0, counters 0.
